alu_op_decoder: RTL and testbench

- Single-cycle registered ALU stage.
- Takes a packed 32-bit function word (opcode, set-flags bit, two 12-bit operands) from the upstream function decoder, plus the current NZCV flags.
- Produces a registered 32-bit result, a one-cycle acknowledge and the next NZCV flags for the flag register.

---
 rtl/alu_op_decoder_pkg.sv | 51 +++++
 rtl/alu_op_decoder_core.sv | 84 ++++++++
 rtl/alu_op_decoder.sv | 92 +++++++++
 tb/tb_alu_op_decoder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_op_decoder_pkg.sv
// Shared definitions for the registered ALU stage: opcode encoding,
// function-word field positions, operand width and the result bundle
// produced by the combinational core.
package alu_op_decoder_pkg;

  // Function word layout: [31:28] opcode, [27] S, [26:24] reserved,
  // [23:12] operand A, [11:0] operand B.
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned OPND_W   = 12;
  localparam int unsigned OP_MSB   = 31;
  localparam int unsigned OP_LSB   = 28;
  localparam int unsigned S_BIT    = 27;
  localparam int unsigned RSVD_MSB = 26;
  localparam int unsigned RSVD_LSB = 24;
  localparam int unsigned A_MSB    = 23;
  localparam int unsigned A_LSB    = 12;
  localparam int unsigned B_MSB    = 11;
  localparam int unsigned B_LSB    = 0;
  localparam int unsigned SHAMT_W  = 5;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_ADC = 4'h2,
    OP_SUB = 4'h3,
    OP_SBC = 4'h4,
    OP_AND = 4'h5,
    OP_ORR = 4'h6,
    OP_EOR = 4'h7,
    OP_NOT = 4'h8,
    OP_LSL = 4'h9,
    OP_LSR = 4'hA,
    OP_ASR = 4'hB,
    OP_ROR = 4'hC,
    OP_MOV = 4'hD,  // MUL when ALU_OP_DECODER_MUL_EN is defined
    OP_CMP = 4'hE,
    OP_TST = 4'hF
  } op_e;

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic              c;
    logic              v;
  } core_res_t;

  // Zero-extend a 12-bit operand field to the datapath width.
  function automatic logic [WORD_W-1:0] zext_opnd(input logic [OPND_W-1:0] f);
    return {{(WORD_W-OPND_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/alu_op_decoder_core.sv
// Combinational ALU core: computes the 32-bit result plus the C and V
// flags for every opcode. N/Z and flag write policy live in the top.
// Optional feature: define ALU_OP_DECODER_MUL_EN to turn opcode D into MUL.
module alu_op_decoder_core
  import alu_op_decoder_pkg::*;
(
  input  op_e               op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cf_in,
  input  logic              vf_in,
  output core_res_t         res
);

  logic [SHAMT_W-1:0] shamt;
  logic [WORD_W:0]    sum_add;
  logic [WORD_W:0]    sum_sub;
  logic               v_add;
  logic               v_sub;
  logic [SHAMT_W-1:0] lsl_idx;
  logic [SHAMT_W-1:0] rsh_idx;

  assign shamt = b[SHAMT_W-1:0];

  // Carry-in is cf for ADC; for SBC, A-B-!C equals A+~B+C, so the same
  // adder serves both subtract forms with C = NOT borrow.
  assign sum_add = {1'b0, a} + {1'b0, b}  + {{WORD_W{1'b0}}, (op == OP_ADC) & cf_in};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{WORD_W{1'b0}}, (op == OP_SBC) ? cf_in : 1'b1};

  assign v_add = (a[WORD_W-1] == b[WORD_W-1]) & (sum_add[WORD_W-1] != a[WORD_W-1]);
  assign v_sub = (a[WORD_W-1] != b[WORD_W-1]) & (sum_sub[WORD_W-1] != a[WORD_W-1]);

  // Bit index of the last bit shifted out (valid only for shamt != 0).
  assign lsl_idx = SHAMT_W'(6'd32 - {1'b0, shamt});
  assign rsh_idx = shamt - 5'd1;

  // Opcode-indexed result and C/V selection.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    res.result = a;
    res.c      = cf_in;
    res.v      = vf_in;
    case (op)
      OP_ADD, OP_ADC: begin
        res.result = sum_add[WORD_W-1:0];
        res.c      = sum_add[WORD_W];
        res.v      = v_add;
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        res.result = sum_sub[WORD_W-1:0];
        res.c      = sum_sub[WORD_W];
        res.v      = v_sub;
      end
      OP_AND, OP_TST: res.result = a & b;
      OP_ORR:         res.result = a | b;
      OP_EOR:         res.result = a ^ b;
      OP_NOT:         res.result = ~a;
      OP_LSL: begin
        res.result = a << shamt;
        if (shamt != '0) res.c = a[lsl_idx];
      end
      OP_LSR: begin
        res.result = a >> shamt;
        if (shamt != '0) res.c = a[rsh_idx];
      end
      OP_ASR: begin
        res.result = $unsigned($signed(a) >>> shamt);
        if (shamt != '0) res.c = a[rsh_idx];
      end
      OP_ROR: begin
        res.result = (a >> shamt) | (a << (6'd32 - {1'b0, shamt}));
        if (shamt != '0) res.c = res.result[WORD_W-1];
      end
`ifdef ALU_OP_DECODER_MUL_EN
      OP_MOV:         res.result = a * b;
`else
      OP_MOV:         res.result = b;
`endif
      default:        res.result = a;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Single-cycle registered ALU stage. Splits the packed function word,
// runs the combinational core, derives N/Z, applies the flag-write
// policy (S bit, CMP/TST always, NOP holds) and registers all outputs.
// Optional feature: define ALU_OP_DECODER_MUL_EN to turn opcode D into MUL.
module alu_op_decoder
  import alu_op_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_b,
  input  logic [WORD_W-1:0] fnct_out,
  input  logic              cf_curr,
  input  logic              nf_curr,
  input  logic              zf_curr,
  input  logic              vf_curr,
  output logic [WORD_W-1:0] alu_out,
  output logic              alu_ack,
  output logic              cf,
  output logic              nf,
  output logic              zf,
  output logic              vf
);

  op_e               op;
  logic              set_flags;
  logic [WORD_W-1:0] opnd_a;
  logic [WORD_W-1:0] opnd_b;
  logic              unused_rsvd;
  core_res_t         core_res;

  logic              out_we;
  logic              flag_we;
  logic              cf_nxt;
  logic              nf_nxt;
  logic              zf_nxt;
  logic              vf_nxt;

  assign op          = op_e'(fnct_out[OP_MSB:OP_LSB]);
  assign set_flags   = fnct_out[S_BIT];
  assign opnd_a      = zext_opnd(fnct_out[A_MSB:A_LSB]);
  assign opnd_b      = zext_opnd(fnct_out[B_MSB:B_LSB]);
  // Reserved bits are deliberately ignored.
  assign unused_rsvd = ^fnct_out[RSVD_MSB:RSVD_LSB];

  alu_op_decoder_core u_core (
    .op    (op),
    .a     (opnd_a),
    .b     (opnd_b),
    .cf_in (cf_curr),
    .vf_in (vf_curr),
    .res   (core_res)
  );

  // Result write enable and next-flag selection.
  always_comb begin
    out_we  = (op != OP_NOP) && (op != OP_CMP) && (op != OP_TST);
    flag_we = (op != OP_NOP);
    cf_nxt  = cf_curr;
    nf_nxt  = nf_curr;
    zf_nxt  = zf_curr;
    vf_nxt  = vf_curr;
    if (set_flags || (op == OP_CMP) || (op == OP_TST)) begin
      cf_nxt = core_res.c;
      nf_nxt = core_res.result[WORD_W-1];
      zf_nxt = (core_res.result == '0);
      vf_nxt = core_res.v;
    end
  end

  // Output registers; NOP holds result and flags and drops the ack.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      alu_out <= '0;
      alu_ack <= 1'b0;
      cf      <= 1'b0;
      nf      <= 1'b0;
      zf      <= 1'b0;
      vf      <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      alu_ack <= (op != OP_NOP);
      if (out_we) alu_out <= core_res.result;
      if (flag_we) begin
        cf <= cf_nxt;
        nf <= nf_nxt;
        zf <= zf_nxt;
        vf <= vf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed-vector bench for alu_op_decoder with hand-computed expectations.
module tb_alu_op_decoder;

  logic        clk;
  logic        rst_b;
  logic [31:0] fnct_out;
  logic        cf_curr, nf_curr, zf_curr, vf_curr;
  logic [31:0] alu_out;
  logic        alu_ack;
  logic        cf, nf, zf, vf;

  int n_vec;
  int n_err;

  alu_op_decoder dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .fnct_out (fnct_out),
    .cf_curr  (cf_curr),
    .nf_curr  (nf_curr),
    .zf_curr  (zf_curr),
    .vf_curr  (vf_curr),
    .alu_out  (alu_out),
    .alu_ack  (alu_ack),
    .cf       (cf),
    .nf       (nf),
    .zf       (zf),
    .vf       (vf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare every output against the expected set.
  task automatic expect_all(input string tag, input logic [31:0] e_out, input logic e_ack,
                            input logic e_c, input logic e_n, input logic e_z, input logic e_v);
    check({tag, ".out"}, alu_out, e_out);
    check({tag, ".ack"}, {31'd0, alu_ack}, {31'd0, e_ack});
    check({tag, ".c"},   {31'd0, cf}, {31'd0, e_c});
    check({tag, ".n"},   {31'd0, nf}, {31'd0, e_n});
    check({tag, ".z"},   {31'd0, zf}, {31'd0, e_z});
    check({tag, ".v"},   {31'd0, vf}, {31'd0, e_v});
  endtask

  // Drive a word and current flags at the falling edge, then step past the
  // next rising edge so the registered result is visible.
  task automatic apply(input logic [31:0] w, input logic c, input logic n,
                       input logic z, input logic v);
    @(negedge clk);
    fnct_out = w;
    cf_curr  = c;
    nf_curr  = n;
    zf_curr  = z;
    vf_curr  = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_b    = 1'b1;
    fnct_out = '0;
    {cf_curr, nf_curr, zf_curr, vf_curr} = 4'b0000;

    // Reset asserted mid-cycle takes effect without a clock edge.
    #2 rst_b = 1'b0;
    #1 expect_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b1;
    apply(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("nop_after_reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // LSR A=0xAAA by 10 with S=1: 2, last bit out A[9]=1.
    apply(32'hAAAA_AAAA, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_all("lsr", 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply(32'hAAAA_AAAA, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_all("lsr_hold", 32'h2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ADD S=1 0xFFF+1; current flags all set to prove they are replaced.
    apply(32'h18FF_F001, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_all("add", 32'h0000_1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // SUB S=1 equal operands: zero, no borrow.
    apply(32'h3812_3123, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("sub_eq", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // ORR S=0: flags pass through from current inputs.
    apply(32'h6000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_all("orr_pass", 32'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    // ORR S=0 to leave 0x55 in the result register.
    apply(32'h6000_0055, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("orr_55", 32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // CMP 1-2: flags written without S, result held.
    apply(32'hE000_1002, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("cmp", 32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // NOP: ack drops, result and flags hold despite different current flags.
    apply(32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_all("nop_hold", 32'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // ADC S=1 1+2+1.
    apply(32'h2800_1002, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("adc", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // SBC S=1 5-3-!0 = 1, no borrow.
    apply(32'h4800_5003, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("sbc", 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // LSL S=1 0x800 by 21: all bits out, last one A[11]=1.
    apply(32'h9880_0015, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("lsl", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // ASR S=1 3 by 1.
    apply(32'hB800_3001, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("asr", 32'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ROR S=1 1 by 1: wraps into bit 31, C = result[31].
    apply(32'hC800_1001, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_all("ror", 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // NOT S=1 of 0: C and V pass through.
    apply(32'h8800_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_all("not", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // EOR S=1.
    apply(32'h78F0_F0FF, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("eor", 32'h0000_0FF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // AND S=0.
    apply(32'h50F0_F0FF, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_all("and", 32'h0000_000F, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // LSR by 0 (B[4:0]=0): result A, C = cf_curr.
    apply(32'hA812_3020, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("lsr_zero", 32'h0000_0123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // TST 0x0F0 & 0x00F: Z set, result held, C passes.
    apply(32'hF00F_000F, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_all("tst", 32'h0000_0123, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reserved bits set on ADD S=0: result unaffected.
    apply(32'h1700_1002, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_all("rsvd", 32'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

    // Opcode D: MUL when enabled, MOV otherwise.
    apply(32'hD001_0020, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_OP_DECODER_MUL_EN
    expect_all("op_d_mul", 32'h0000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    expect_all("op_d_mov", 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Reset mid-operation with a non-NOP word held clears immediately.
    apply(32'h18FF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_b = 1'b0;
    #1 expect_all("reset_mid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fnct_out = '0;
    @(negedge clk);
    rst_b = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
